// File: rtl/acc_res_norm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fixp_acc_pkg
// Purpose  : Shared widths and packet types for the accumulator result path.
// Revision : 1.0
// ============================================================================
package fixp_acc_pkg;
   localparam int ACC_W       = 256;
   localparam int FRAC_BITS   = 128;
   localparam int CS_W        = 8;
   localparam int FP32_BIAS   = 127;
   localparam int FP32_MANT_W = 23;

   typedef struct packed {
      logic [CS_W-1:0]  cs;
      logic [ACC_W-1:0] acc;
   } res_pkt_t;

   typedef struct packed {
      logic [CS_W-1:0] cs;
      logic [31:0]     fp32;
   } fp_pkt_t;
endpackage
`default_nettype wire

// File: rtl/acc_res_norm_lzc.sv
`default_nettype none
// ============================================================================
// Module   : acc_lzc
// Purpose  : Combinational tree leading-one detector (position + zero flag).
// Revision : 1.0
// ============================================================================
module acc_lzc #(
   parameter int W = 257
) (
   input  logic [W-1:0]         data_i,
   output logic [$clog2(W)-1:0] pos_o,
   output logic                 zero_o
);
   localparam int LV = $clog2(W);
   localparam int N  = 1 << LV;

   logic [N-1:0] w_pad;
   assign w_pad = N'(data_i);

   // Each level merges sibling pairs in place; the upper child wins and
   // contributes bit k of the position.
   always_comb begin
      logic          vld [N];
      logic [LV-1:0] pos [N];
      for (int i = 0; i < N; i++) begin
         vld[i] = w_pad[i];
         pos[i] = '0;
      end
      for (int k = 0; k < LV; k++) begin
         for (int j = 0; j < (N >> (k + 1)); j++) begin
            pos[j] = vld[2*j+1] ? (pos[2*j+1] | (LV'(1) << k)) : pos[2*j];
            vld[j] = vld[2*j+1] | vld[2*j];
         end
      end
      pos_o  = pos[0];
      zero_o = ~vld[0];
   end
endmodule
`default_nettype wire

// File: rtl/acc_res_norm.sv
`default_nettype none
// ============================================================================
// Module   : acc_res_norm
// Purpose  : 3-stage fixed-point sum to FP32 (RNE, flush-to-zero) converter.
//            Optional ACC_NORM_STATS_EN adds overflow/underflow counters.
// Revision : 1.0
// ============================================================================
module acc_res_norm #(
   parameter int ACC_W     = fixp_acc_pkg::ACC_W,
   parameter int FRAC_BITS = fixp_acc_pkg::FRAC_BITS,
   parameter int CS_W      = fixp_acc_pkg::CS_W
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef ACC_NORM_STATS_EN
   input  logic                  stats_clr_i,
   output logic [15:0]           ovf_cnt_o,
   output logic [15:0]           unf_cnt_o,
`endif
   input  logic [CS_W+ACC_W-1:0] res_pkt_tdata_i,
   input  logic                  res_pkt_tvalid_i,
   output logic                  res_pkt_tready_o,
   output logic [CS_W+31:0]      fp_out_tdata_o,
   output logic                  fp_out_tvalid_o,
   input  logic                  fp_out_tready_i
);
   import fixp_acc_pkg::*;

   localparam int MW = ACC_W + 1;
   localparam int PW = $clog2(MW);

   logic v1_q, v2_q, v3_q;
   logic ld1, ld2, ld3;

   assign ld3 = ~v3_q | fp_out_tready_i;
   assign ld2 = ~v2_q | ld3;
   assign ld1 = ~v1_q | ld2;
   assign res_pkt_tready_o = ld1;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else begin
         if (ld1) v1_q <= res_pkt_tvalid_i;
         if (ld2) v2_q <= v1_q;
         if (ld3) v3_q <= v2_q;
      end
   end

   // S1: magnitude one bit wider than the sum so the most negative value is exact
   logic [ACC_W-1:0] w_acc;
   logic [MW-1:0]    w_sext, w_mag1_d;
   logic [CS_W-1:0]  cs1_q;
   logic             sign1_q;
   logic [MW-1:0]    mag1_q;

   assign w_acc    = res_pkt_tdata_i[ACC_W-1:0];
   assign w_sext   = {w_acc[ACC_W-1], w_acc};
   assign w_mag1_d = w_acc[ACC_W-1] ? (~w_sext + MW'(1)) : w_sext;

   always_ff @(posedge clk) begin
      if (ld1) begin
         cs1_q   <= res_pkt_tdata_i[CS_W+ACC_W-1 -: CS_W];
         sign1_q <= w_acc[ACC_W-1];
         mag1_q  <= w_mag1_d;
      end
   end

   // S2: leading-one search
   logic [PW-1:0]   w_pos;
   logic            w_zero;
   logic [CS_W-1:0] cs2_q;
   logic            sign2_q, zero2_q;
   logic [MW-1:0]   mag2_q;
   logic [PW-1:0]   pos2_q;

   acc_lzc #(.W(MW)) u_lzc (
      .data_i (mag1_q),
      .pos_o  (w_pos),
      .zero_o (w_zero)
   );

   always_ff @(posedge clk) begin
      if (ld2) begin
         cs2_q   <= cs1_q;
         sign2_q <= sign1_q;
         mag2_q  <= mag1_q;
         pos2_q  <= w_pos;
         zero2_q <= w_zero;
      end
   end

   // S3: the leading one is shifted out past the top, leaving the fraction
   // bits aligned at ACC_W-1 followed by guard and sticky.
   logic [PW-1:0]             w_sh;
   logic [ACC_W-1:0]          w_norm;
   logic [FP32_MANT_W-1:0]    w_mant;
   logic                      w_guard, w_sticky, w_rnd;
   logic [FP32_MANT_W:0]      w_mant_inc;
   logic signed [15:0]        w_exp;
   logic                      w_ovf, w_unf;
   logic [31:0]               w_fp32;
   logic [CS_W+31:0]          out_q;

   assign w_sh       = PW'(ACC_W) - pos2_q;
   assign w_norm     = ACC_W'(mag2_q << w_sh);
   assign w_mant     = w_norm[ACC_W-1 -: FP32_MANT_W];
   assign w_guard    = w_norm[ACC_W-FP32_MANT_W-1];
   assign w_sticky   = |w_norm[ACC_W-FP32_MANT_W-2:0];
   assign w_rnd      = w_guard & (w_sticky | w_mant[0]);
   assign w_mant_inc = {1'b0, w_mant} + (FP32_MANT_W+1)'(w_rnd);
   assign w_exp      = 16'(pos2_q) + 16'(FP32_BIAS - FRAC_BITS) + 16'(w_mant_inc[FP32_MANT_W]);
   assign w_ovf      = ~zero2_q & (w_exp >= 16'sd255);
   assign w_unf      = ~zero2_q & (w_exp <= 16'sd0);

   always_comb begin
      w_fp32 = {sign2_q, w_exp[7:0], w_mant_inc[FP32_MANT_W-1:0]};
      if (zero2_q)     w_fp32 = 32'h0000_0000;
      else if (w_ovf)  w_fp32 = {sign2_q, 8'hFF, 23'd0};
      else if (w_unf)  w_fp32 = {sign2_q, 31'd0};
   end

   always_ff @(posedge clk) begin
      if (rst)      out_q <= '0;
      else if (ld3) out_q <= {cs2_q, w_fp32};
   end

   assign fp_out_tdata_o  = out_q;
   assign fp_out_tvalid_o = v3_q;

`ifdef ACC_NORM_STATS_EN
   logic        ovf3_q, unf3_q;
   logic [15:0] ovf_cnt_q, unf_cnt_q;
   logic        w_leave;

   assign w_leave = v3_q & fp_out_tready_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf3_q <= 1'b0;
         unf3_q <= 1'b0;
      end else if (ld3) begin
         ovf3_q <= v2_q & w_ovf;
         unf3_q <= v2_q & w_unf;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || stats_clr_i) begin
         ovf_cnt_q <= '0;
         unf_cnt_q <= '0;
      end else begin
         if (w_leave && ovf3_q && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
         if (w_leave && unf3_q && unf_cnt_q != 16'hFFFF) unf_cnt_q <= unf_cnt_q + 16'd1;
      end
   end

   assign ovf_cnt_o = ovf_cnt_q;
   assign unf_cnt_o = unf_cnt_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_acc_res_norm.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_res_norm
// Purpose  : Scoreboard bench for acc_res_norm with a fixed-to-float model.
// Revision : 1.0
// ============================================================================
module tb_acc_res_norm;
   import fixp_acc_pkg::*;

   localparam int MW = ACC_W + 1;

   typedef struct {
      fp_pkt_t pkt;
      bit      ovf;
      bit      unf;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   res_pkt_t        in_pkt;
   logic            in_valid, in_ready;
   logic [CS_W+31:0] out_data;
   logic            out_valid, out_ready;
`ifdef ACC_NORM_STATS_EN
   logic            stats_clr;
   logic [15:0]     ovf_cnt, unf_cnt;
`endif

   always #5 clk = ~clk;

   acc_res_norm dut (
      .clk              (clk),
      .rst              (rst),
`ifdef ACC_NORM_STATS_EN
      .stats_clr_i      (stats_clr),
      .ovf_cnt_o        (ovf_cnt),
      .unf_cnt_o        (unf_cnt),
`endif
      .res_pkt_tdata_i  (in_pkt),
      .res_pkt_tvalid_i (in_valid),
      .res_pkt_tready_o (in_ready),
      .fp_out_tdata_o   (out_data),
      .fp_out_tvalid_o  (out_valid),
      .fp_out_tready_i  (out_ready)
   );

   exp_t exp_q[$];
   int   checks = 0, failures = 0;
   int   exp_ovf = 0, exp_unf = 0;
   int   accepted = 0;
   bit   rand_rdy = 1'b0;

   // Exact real value acc*2^-FRAC_BITS rounded to 24 significant bits, RNE.
   function automatic void ref_model(input logic [ACC_W-1:0] acc,
                                     output logic [31:0] fp, output bit ovf, output bit unf);
      logic          neg;
      logic [MW-1:0] mag, sig, rem, half;
      int            p, e;
      neg = acc[ACC_W-1];
      mag = neg ? (MW'(0) - {1'b1, acc}) : {1'b0, acc};
      ovf = 0; unf = 0;
      if (mag == '0) begin fp = 32'h0; return; end
      p = MW - 1;
      while (!mag[p]) p--;
      if (p > 23) begin
         sig  = mag >> (p - 23);
         rem  = mag - (sig << (p - 23));
         half = MW'(1) << (p - 24);
         if (rem > half || (rem == half && sig[0])) sig = sig + MW'(1);
      end else begin
         sig = mag << (23 - p);
      end
      e = p - FRAC_BITS + FP32_BIAS;
      if (sig == (MW'(1) << 24)) begin sig = sig >> 1; e++; end
      if (e >= 255)     begin fp = {neg, 8'hFF, 23'd0}; ovf = 1; end
      else if (e <= 0)  begin fp = {neg, 31'd0};        unf = 1; end
      else              fp = {neg, 8'(e), sig[22:0]};
   endfunction

   task automatic send(input logic [CS_W-1:0] cs, input logic [ACC_W-1:0] acc,
                       input bit force_exp, input logic [31:0] exp_fp);
      exp_t e;
      logic [31:0] mfp;
      int n = 0;
      ref_model(acc, mfp, e.ovf, e.unf);
      e.pkt.cs   = cs;
      e.pkt.fp32 = force_exp ? exp_fp : mfp;
      in_pkt.cs  = cs;
      in_pkt.acc = acc;
      in_valid   = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            accepted++;
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         n++;
         if (n > 500) begin
            checks++; failures++;
            $display("FAIL send_timeout cs=%0d got no tready, required tready=1", cs);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s got=%0d pending required=0", name, exp_q.size());
      end
   endtask

   // Monitor: pops on each output transfer and checks stability while stalled.
   initial begin
      bit               hold = 0;
      logic [CS_W+31:0] held = '0;
      exp_t             e;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 0;
         end else begin
            if (hold) begin
               checks++;
               if (!out_valid || out_data !== held) begin
                  failures++;
                  $display("FAIL stall_stable got v=%b d=%h required v=1 d=%h", out_valid, out_data, held);
               end
            end
            if (out_valid && out_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_out got=%h required=none", out_data);
               end else begin
                  e = exp_q.pop_front();
                  if (out_data !== e.pkt) begin
                     failures++;
                     $display("FAIL out_pkt got=%h required=%h", out_data, e.pkt);
                  end
                  if (e.ovf && exp_ovf < 65535) exp_ovf++;
                  if (e.unf && exp_unf < 65535) exp_unf++;
               end
            end
            hold = out_valid && !out_ready;
            held = out_data;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   function automatic logic [ACC_W-1:0] rand_acc();
      logic signed [ACC_W-1:0] a;
      logic [ACC_W-1:0]        one;
      int                      k;
      for (int i = 0; i < ACC_W / 32; i++) a[32*i +: 32] = $urandom;
      k   = $urandom_range(0, ACC_W - 1);
      one = 1;
      case ($urandom_range(0, 3))
         0: ;
         1: a = a >>> k;
         2: a = $unsigned(a) >> k;
         default: case ($urandom_range(0, 5))
            0: a = '0;
            1: a = one;
            2: a = '1;
            3: a = one << (ACC_W - 1);
            4: a = one << k;
            default: a = (one << k) - one;
         endcase
      endcase
      return a;
   endfunction

   initial begin
      logic [ACC_W-1:0] v, one;
      int n;
      one       = 1;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_pkt    = '0;
      out_ready = 1'b1;
`ifdef ACC_NORM_STATS_EN
      stats_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_tvalid", 64'(out_valid), 64'd0);
      check("rst_tdata",  64'(out_data),  64'd0);
      check("rst_tready", 64'(in_ready),  64'd1);
      @(posedge clk); #1;

      // Latency: one packet into an empty pipe appears on the third negedge.
      send(8'd3, one << 128, 1, 32'h3F80_0000);
      n = 0;
      while (!out_valid && n < 10) begin @(negedge clk); n++; end
      check("latency", 64'(n), 64'd3);
      @(posedge clk); #1;

      send(8'd7,  -(ACC_W'(3) << 127), 1, 32'hBFC0_0000);
      send(8'd5,  '0, 1, 32'h0000_0000);
      send(8'd1,  (one << 128) + (one << 104), 1, 32'h3F80_0000);
      send(8'd2,  (one << 128) + (one << 104) + (one << 103), 1, 32'h3F80_0001);
      send(8'd9,  (one << 152) - one, 1, 32'h4B80_0000);
      send(8'd10, one, 1, 32'h0000_0000);
      send(8'd11, '1, 1, 32'h8000_0000);
      send(8'hFF, one << (ACC_W - 1), 1, 32'hFF00_0000);
      wait_drain("directed_drain", 50);
      @(posedge clk); #1;
`ifdef ACC_NORM_STATS_EN
      check("unf_cnt_dir", 64'(unf_cnt), 64'(exp_unf));
      check("ovf_cnt_dir", 64'(ovf_cnt), 64'(exp_ovf));
      stats_clr = 1'b1;
      @(posedge clk); #1;
      stats_clr = 1'b0;
      exp_ovf = 0; exp_unf = 0;
      check("unf_cnt_clr", 64'(unf_cnt), 64'd0);
`endif

      // Backpressure: 8 packets against a stalled sink.
      out_ready = 1'b0;
      accepted  = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) send(8'(16 + i), rand_acc(), 0, 32'h0);
         end
      join_none
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("bp_accepted", 64'(accepted), 64'd3);
      check("bp_tready",   64'(in_ready), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      n = 0;
      while ((accepted < 8 || exp_q.size() != 0) && n < 200) begin @(posedge clk); n++; end
      check("bp_all_out", 64'(accepted - exp_q.size()), 64'd8);
      #1;

      // Reset with two packets in flight: both must vanish.
      out_ready = 1'b0;
      send(8'hA1, one << 130, 0, 32'h0);
      send(8'hA2, one << 131, 0, 32'h0);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      exp_ovf = 0; exp_unf = 0;
      @(negedge clk);
      check("rst_flush_tvalid", 64'(out_valid), 64'd0);
      check("rst_flush_tready", 64'(in_ready),  64'd1);
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_flush_quiet", 64'(out_valid), 64'd0);
      @(posedge clk); #1;

      // Random traffic with random sink readiness.
      rand_rdy = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
         send(8'($urandom), rand_acc(), 0, 32'h0);
      end
      wait_drain("random_drain", 1000);
      rand_rdy  = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
`ifdef ACC_NORM_STATS_EN
      check("unf_cnt_rand", 64'(unf_cnt), 64'(exp_unf));
      check("ovf_cnt_rand", 64'(ovf_cnt), 64'(exp_ovf));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
